// File: rtl/nes_addr_capture.sv
// nes_addr_capture: queues NES address-request strobes in a FIFO and presents the head to a NIOS input PIO.
// Ports: clk/reset_n (async active-low); req_valid/req_addr push a request;
// ack_toggle pops one entry per level change; clr_ovf clears overflow;
// addr_out/addr_valid registered head entry; fill_level entry count; overflow sticky drop flag.
module nes_addr_capture #(
  parameter int ADDR_W  = 24,
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic               ack_toggle,
  input  logic               clr_ovf,
  output logic [ADDR_W-1:0]  addr_out,
  output logic               addr_valid,
  output logic [FIFO_AW:0]   fill_level,
  output logic               overflow
);
  logic [ADDR_W-1:0] mem [2**FIFO_AW];
  logic [FIFO_AW:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic              ack_q, primed, full, empty, pop_ok, push_ok, drop;
  logic [ADDR_W-1:0] head;
  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) && (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign empty   = wr_ptr == rd_ptr;
  // primed masks the first cycle after reset so a PIO level left high is only captured
  assign pop_ok  = primed && (ack_toggle != ack_q) && !empty;
  assign push_ok = req_valid && (!full || pop_ok);
  assign drop    = req_valid && full && !pop_ok;
  assign wr_nxt  = wr_ptr + {{FIFO_AW{1'b0}}, push_ok};
  assign rd_nxt  = rd_ptr + {{FIFO_AW{1'b0}}, pop_ok};
  // the entry being written this edge becomes the head when it lands at the new read pointer
  assign head    = (push_ok && wr_ptr == rd_nxt) ? req_addr : mem[rd_nxt[FIFO_AW-1:0]];
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= req_addr;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ack_q      <= 1'b0;
      primed     <= 1'b0;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      fill_level <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_ptr     <= wr_nxt;
      rd_ptr     <= rd_nxt;
      ack_q      <= ack_toggle;
      primed     <= 1'b1;
      addr_out   <= (wr_nxt == rd_nxt) ? '0 : head;
      addr_valid <= wr_nxt != rd_nxt;
      fill_level <= wr_nxt - rd_nxt;
      overflow   <= drop ? 1'b1 : clr_ovf ? 1'b0 : overflow;
    end
endmodule

// File: tb/tb_nes_addr_capture.sv
// tb_nes_addr_capture: directed self-checking bench for nes_addr_capture.
module tb_nes_addr_capture;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [23:0] req_addr = '0;
  logic        ack_toggle = 1'b1;
  logic        clr_ovf = 1'b0;
  logic [23:0] addr_out;
  logic        addr_valid;
  logic [3:0]  fill_level;
  logic        overflow;
  int          errors = 0;
  int          checks = 0;
  logic [23:0] q[$];

  nes_addr_capture dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .ack_toggle(ack_toggle), .clr_ovf(clr_ovf), .addr_out(addr_out),
    .addr_valid(addr_valid), .fill_level(fill_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [23:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic pop();
    ack_toggle = ~ack_toggle;
    tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_addr", addr_out, 0);
    chk("rst_valid", addr_valid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    repeat (4) tick();
    chk("idle_valid", addr_valid, 0);
    chk("idle_fill", fill_level, 0);

    push(24'h123456);
    chk("p1_addr", addr_out, 24'h123456);
    chk("p1_valid", addr_valid, 1);
    push(24'hABCDEF);
    chk("p2_fill", fill_level, 2);
    chk("p2_addr", addr_out, 24'h123456);
    pop();
    chk("pop1_addr", addr_out, 24'hABCDEF);
    chk("pop1_fill", fill_level, 1);
    pop();
    chk("pop2_addr", addr_out, 0);
    chk("pop2_valid", addr_valid, 0);
    chk("pop2_fill", fill_level, 0);

    for (int i = 1; i <= 8; i++) push(24'(i));
    chk("full_fill", fill_level, 8);
    chk("full_ovf", overflow, 0);
    push(24'h000009);
    chk("drop_fill", fill_level, 8);
    chk("drop_ovf", overflow, 1);
    chk("drop_head", addr_out, 1);
    for (int i = 2; i <= 8; i++) begin
      pop();
      chk("drain_addr", addr_out, 24'(i));
    end
    pop();
    chk("drain_valid", addr_valid, 0);
    chk("drain_fill", fill_level, 0);
    pop();
    chk("pop_empty_fill", fill_level, 0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 0);

    for (int i = 0; i < 8; i++) push(24'h10 + 24'(i));
    req_valid  = 1'b1;
    req_addr   = 24'h0000AA;
    ack_toggle = ~ack_toggle;
    tick();
    req_valid = 1'b0;
    chk("pp_fill", fill_level, 8);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", addr_out, 24'h11);
    repeat (7) pop();
    chk("pp_last", addr_out, 24'hAA);
    chk("pp_last_fill", fill_level, 1);
    pop();
    chk("pp_empty", addr_valid, 0);

    for (int i = 0; i < 8; i++) push(24'h20 + 24'(i));
    req_valid = 1'b1;
    req_addr  = 24'hDEAD;
    clr_ovf   = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("set_beats_clr", overflow, 1);
    tick();
    clr_ovf = 1'b0;
    chk("clr_alone", overflow, 0);
    repeat (7) pop();
    chk("ovf_drain", addr_out, 24'h27);
    pop();
    chk("ovf_empty", fill_level, 0);

    q = {};
    for (int i = 0; i < 20; i++) begin
      logic do_push, do_pop;
      if (i == 12) begin
        reset_n = 1'b0;
        #1;
        chk("mid_rst_addr", addr_out, 0);
        chk("mid_rst_valid", addr_valid, 0);
        chk("mid_rst_fill", fill_level, 0);
        chk("mid_rst_ovf", overflow, 0);
        q = {};
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_valid", addr_valid, 0);
      end
      do_push = (i % 3) != 2;
      do_pop  = (i % 2) == 1;
      req_valid = do_push;
      req_addr  = 24'h300 + 24'(i);
      if (do_pop) ack_toggle = ~ack_toggle;
      if (do_pop && q.size() > 0) void'(q.pop_front());
      if (do_push && q.size() < 8) q.push_back(24'h300 + 24'(i));
      tick();
      req_valid = 1'b0;
      chk("wrap_addr", addr_out, q.size() > 0 ? q[0] : 24'h0);
      chk("wrap_fill", fill_level, q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nes_addr_capture.md
Name: nes_addr_capture

Overview:
- Upstream feeder for the 24-bit NIOS address input PIO.
- Captures address-request strobes from the NES core's cartridge/memory bus and queues them in a small FIFO.
- Presents the oldest pending address, registered, as the PIO's 24-bit input word.
- NIOS software pops entries by toggling a bit on an output PIO, so no NES request is lost while software services the previous one.

Parameters:
ADDR_W, 24, address width; must match the PIO input width.
FIFO_AW, 3, log2 of FIFO depth (default depth 8); the depth is always a power of two.

Ports:
clk  input  1  system clock; single clock domain.
reset_n  input  1  asynchronous, active-low reset.
req_valid  input  1  one-cycle strobe from the NES core: req_addr is a new request.
req_addr  input  ADDR_W  request address, sampled when req_valid=1.
ack_toggle  input  1  level driven by a NIOS output PIO; each change of level requests one pop.
clr_ovf  input  1  synchronous clear of the overflow flag.
addr_out  output  ADDR_W  head-of-FIFO address; connects to the PIO in_port.
addr_valid  output  1  1 when addr_out holds a pending entry.
fill_level  output  FIFO_AW+1  number of queued entries, 0..2^FIFO_AW.
overflow  output  1  sticky flag: a request was dropped because the FIFO was full.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - addr_out=0, addr_valid=0, fill_level=0, overflow=0.
  - Read and write pointers =0.
  - ack_q=0, primed=0.
  - Reset mid-operation discards all queued entries immediately.
- Storage: circular buffer of 2^FIFO_AW entries. Write and read pointers are FIFO_AW+1 bits wide and wrap modulo 2^(FIFO_AW+1).
  - Full when pointer MSBs differ and the low bits are equal.
  - Empty when the pointers are equal.
- Pop detection:
  - ack_q registers ack_toggle every cycle.
  - pop_req = primed & (ack_toggle != ack_q).
  - primed goes to 1 on the first clock after reset release. That first cycle only captures ack_toggle, so a PIO level left high at reset never causes a spurious pop.
- Push: push_ok = req_valid & (!full | pop_ok). A simultaneous pop frees the slot, so a push is accepted when full if a pop occurs in the same cycle.
- Pop: pop_ok = pop_req & !empty. A pop on empty is ignored and is not remembered.
- Dropped request: req_valid & full & !pop_ok. The request is discarded, pointers are unchanged, and overflow sets.
- overflow:
  - Set has priority over clr_ovf in the same cycle.
  - Otherwise clr_ovf=1 clears it next edge.
- fill_level: registered; +1 on push only, -1 on pop only, unchanged on push+pop.
- Output registers (addr_out, addr_valid) are updated every edge from the post-update state.
  - Non-empty: addr_out = entry at the new read pointer, addr_valid=1.
  - Empty: addr_out=0, addr_valid=0.
- Latency:
  - Push into an empty FIFO at edge N → addr_valid=1 and addr_out valid after edge N, i.e. visible in cycle N+1.
  - ack_toggle change sampled at edge M → pop at edge M. The next head is visible after edge M.
  - The PIO adds its own 1-cycle register.
- Empty FIFO with simultaneous push and pop_req: the pop is ignored and the push is accepted; addr_out shows the pushed address.
- req_addr is captured only on push_ok; at all other times it is don't-care.
- Width rules: no arithmetic on the address itself. All pointer and fill arithmetic is unsigned and wraps naturally.

Test Plan:
- Reset with ack_toggle held at 1, release, wait 4 cycles → addr_valid=0, fill_level=0, no pop, and no pointer movement.
- Push 0x123456 then 0xABCDEF on consecutive cycles → cycle after first push: addr_out=0x123456, addr_valid=1. fill_level=2 after the second push. Toggle ack once → addr_out=0xABCDEF, fill_level=1. Toggle again → addr_out=0, addr_valid=0.
- Push 9 addresses 0x000001..0x000009 with no pops (depth 8) → fill_level=8, overflow=1, 0x000009 dropped. Pops return 0x000001..0x000008 in order, then empty.
- With the FIFO full, assert req_valid=0x0000AA and an ack toggle in the same cycle → push accepted, overflow stays 0, fill_level stays 8. The last entry popped is 0x0000AA.
- Pulse clr_ovf in the same cycle as a dropped push → overflow remains 1. Pulse clr_ovf alone next cycle → overflow=0.
- 20 interleaved push/pop cycles crossing the pointer wrap, with reset_n asserted mid-stream → data order is preserved across the wrap. After reset, all outputs are 0 and stale entries never reappear.
